// File: rtl/decoder_pkg.sv
// Shared constants and types for the 3-to-8 line decoder.
package decoder_pkg;

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned NUM_OUT = 8;

    typedef logic [SEL_W-1:0] sel_t;

endpackage : decoder_pkg

// File: rtl/decoder_3to8_core.sv
// Combinational 3-to-8 decode: {en, a, b, c} -> one-hot vector (all-zero when disabled).
module decoder_3to8_core
    import decoder_pkg::*;
(
    input  logic               en,
    input  logic               a,
    input  logic               b,
    input  logic               c,
    output logic [NUM_OUT-1:0] onehot
);

    sel_t sel;

    assign sel = {a, b, c};

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = {{(NUM_OUT-1){1'b0}}, 1'b1} << sel;
        end
    end

endmodule : decoder_3to8_core

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 line decoder with selectable output polarity.
// Optional registered idx/vld outputs are built when DECODER_3TO8_INDEX_OUT_EN is defined.
module decoder_3to8
    import decoder_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic en,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3,
    output logic d4,
    output logic d5,
    output logic d6,
    output logic d7
`ifdef DECODER_3TO8_INDEX_OUT_EN
    ,
    output logic [SEL_W-1:0] idx,
    output logic             vld
`endif
);

    logic [NUM_OUT-1:0] next_d;
    logic [NUM_OUT-1:0] d_q;

    decoder_3to8_core u_core (
        .en     (en),
        .a      (a),
        .b      (b),
        .c      (c),
        .onehot (next_d)
    );

    // Flops always hold active-high strobes; polarity is applied after the register
    // so reset leaves every output at its idle level for either polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= '0;
        end else begin
            d_q <= next_d;
        end
    end

    assign {d7, d6, d5, d4, d3, d2, d1, d0} = d_q ^ {NUM_OUT{OUT_ACTIVE_LOW}};

`ifdef DECODER_3TO8_INDEX_OUT_EN
    sel_t idx_q;
    logic vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            vld_q <= 1'b0;
        end else begin
            idx_q <= {a, b, c};
            vld_q <= en;
        end
    end

    assign idx = idx_q;
    assign vld = vld_q;
`endif

endmodule : decoder_3to8

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: active-high and active-low instances share stimulus.
module tb_decoder_3to8;
    import decoder_pkg::*;

    logic clk;
    logic rst_n;
    logic a, b, c, en;
    logic d0, d1, d2, d3, d4, d5, d6, d7;
    logic q0, q1, q2, q3, q4, q5, q6, q7;
    logic [7:0] dv, dv_al;
`ifdef DECODER_3TO8_INDEX_OUT_EN
    logic [2:0] idx, idx_al;
    logic       vld, vld_al;
`endif

    int tests = 0;
    int fails = 0;

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .en(en),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7)
`ifdef DECODER_3TO8_INDEX_OUT_EN
        , .idx(idx), .vld(vld)
`endif
    );

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .en(en),
        .d0(q0), .d1(q1), .d2(q2), .d3(q3), .d4(q4), .d5(q5), .d6(q6), .d7(q7)
`ifdef DECODER_3TO8_INDEX_OUT_EN
        , .idx(idx_al), .vld(vld_al)
`endif
    );

    assign dv    = {d7, d6, d5, d4, d3, d2, d1, d0};
    assign dv_al = {q7, q6, q5, q4, q3, q2, q1, q0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the asserted strobe index is the select value when enabled, none otherwise.
    function automatic logic [7:0] model(input int sel, input logic e);
        logic [7:0] v;
        v = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (e && n == sel) v[n] = 1'b1;
        end
        return v;
    endfunction

    task automatic drive(input int sel, input logic e);
        a  = sel[2];
        b  = sel[1];
        c  = sel[0];
        en = e;
    endtask

    // Apply inputs at the falling edge, then sample 1 time unit after the next rising edge.
    task automatic step(input int sel, input logic e);
        @(negedge clk);
        drive(sel, e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(7, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (dv !== 8'h00) begin
            fails++;
            $display("FAIL reset_hold_hi: got %b want %b", dv, 8'h00);
        end
        tests++;
        if (dv_al !== 8'hFF) begin
            fails++;
            $display("FAIL reset_hold_lo: got %b want %b", dv_al, 8'hFF);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (dv !== model(7, 1'b1)) begin
            fails++;
            $display("FAIL reset_release_d7: got %b want %b", dv, model(7, 1'b1));
        end
    endtask

    task automatic test_disable();
        step(0, 1'b0);
        tests++;
        if (dv !== 8'h00) begin
            fails++;
            $display("FAIL disable_all_idle: got %b want %b", dv, 8'h00);
        end
        step(0, 1'b1);
        tests++;
        if (dv !== 8'h01) begin
            fails++;
            $display("FAIL enable_d0: got %b want %b", dv, 8'h01);
        end
        for (int s = 0; s < 8; s++) begin
            step(s, 1'b0);
            tests++;
            if (dv !== 8'h00 || dv_al !== 8'hFF) begin
                fails++;
                $display("FAIL disable_sel%0d: got %b/%b want 00000000/11111111", s, dv, dv_al);
            end
        end
    endtask

    task automatic test_sweep();
        for (int s = 0; s < 8; s++) begin
            step(s, 1'b1);
            tests++;
            if (dv !== model(s, 1'b1) || $countones(dv) != 1) begin
                fails++;
                $display("FAIL sweep_sel%0d: got %b want %b", s, dv, model(s, 1'b1));
            end
        end
    endtask

    task automatic test_async_reset();
        step(5, 1'b1);
        tests++;
        if (dv !== 8'h20) begin
            fails++;
            $display("FAIL async_pre_d5: got %b want %b", dv, 8'h20);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (dv !== 8'h00 || dv_al !== 8'hFF) begin
            fails++;
            $display("FAIL async_clear: got %b/%b want 00000000/11111111", dv, dv_al);
        end
        @(posedge clk);
        #1;
        tests++;
        if (dv !== 8'h00) begin
            fails++;
            $display("FAIL async_held: got %b want %b", dv, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (dv !== 8'h20) begin
            fails++;
            $display("FAIL async_reload_d5: got %b want %b", dv, 8'h20);
        end
    endtask

    task automatic test_active_low();
        step(3, 1'b1);
        tests++;
        if (dv_al !== 8'hF7) begin
            fails++;
            $display("FAIL active_low_d3: got %b want %b", dv_al, 8'hF7);
        end
        step(3, 1'b0);
        tests++;
        if (dv_al !== 8'hFF) begin
            fails++;
            $display("FAIL active_low_idle: got %b want %b", dv_al, 8'hFF);
        end
    endtask

    task automatic test_between_edges();
        step(2, 1'b1);
        // Input change just after an edge must not reach the outputs.
        #1;
        drive(6, 1'b1);
        #1;
        tests++;
        if (dv !== 8'h04) begin
            fails++;
            $display("FAIL no_comb_path: got %b want %b", dv, 8'h04);
        end
        // A glitch that returns before the edge is invisible.
        @(negedge clk);
        drive(1, 1'b1);
        #2;
        drive(2, 1'b1);
        @(posedge clk);
        #1;
        tests++;
        if (dv !== 8'h04) begin
            fails++;
            $display("FAIL glitch_ignored: got %b want %b", dv, 8'h04);
        end
    endtask

    task automatic test_random();
        int s;
        logic e;
        for (int i = 0; i < 200; i++) begin
            s = int'($urandom_range(0, 7));
            e = ($urandom_range(0, 3) != 0);
            step(s, e);
            tests++;
            if (dv !== model(s, e) || dv_al !== ~model(s, e) || $countones(dv) > 1) begin
                fails++;
                $display("FAIL random_%0d sel=%0d en=%b: got %b/%b want %b", i, s, e, dv, dv_al, model(s, e));
            end
        end
    endtask

`ifdef DECODER_3TO8_INDEX_OUT_EN
    task automatic test_index_out();
        logic [2:0] want_idx;
        int s;
        logic e;
        step(6, 1'b1);
        tests++;
        if (idx !== 3'd6 || vld !== 1'b1 || dv !== 8'h40) begin
            fails++;
            $display("FAIL index_d6: got idx=%0d vld=%b d=%b want idx=6 vld=1 d=01000000", idx, vld, dv);
        end
        step(6, 1'b0);
        tests++;
        if (vld !== 1'b0 || dv !== 8'h00 || dv_al !== 8'hFF) begin
            fails++;
            $display("FAIL index_disable: got vld=%b d=%b want vld=0 d=00000000", vld, dv);
        end
        for (int i = 0; i < 40; i++) begin
            s = int'($urandom_range(0, 7));
            e = ($urandom_range(0, 1) != 0);
            want_idx = 3'(s);
            step(s, e);
            tests++;
            if (idx !== want_idx || vld !== e || vld !== ($countones(dv) == 1) || idx_al !== want_idx || vld_al !== e) begin
                fails++;
                $display("FAIL index_rand_%0d: got idx=%0d vld=%b want idx=%0d vld=%b", i, idx, vld, want_idx, e);
            end
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (idx !== 3'd0 || vld !== 1'b0) begin
            fails++;
            $display("FAIL index_async_reset: got idx=%0d vld=%b want idx=0 vld=0", idx, vld);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0);
        test_reset();
        test_disable();
        test_sweep();
        test_async_reset();
        test_active_low();
        test_between_edges();
        test_random();
`ifdef DECODER_3TO8_INDEX_OUT_EN
        test_index_out();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_decoder_3to8
